// File: rtl/sensor_meas_scheduler.sv
// sensor_meas_scheduler
// Arbitrates the SR04 distance controller and the DHT11 controller so that at
// most one measurement is in flight. Button/UART requests and periodic (auto)
// requests are merged into one pending flag per sensor. Each measurement gets
// a start pulse, a bounded wait for its done pulse, and then a send pulse to
// the shared UART TX once the transmitter is free.
//
// Handshake protocol: every request, start, done and send signal is a
// single-cycle strobe with no back-pressure. The only flow control is
// tx_busy, a level: while it is high a completed result is held in SEND_x,
// and the send strobe fires on the first cycle tx_busy is low.
module sensor_meas_scheduler #(
  parameter int SR04_PERIOD_MS  = 100,
  parameter int DHT_PERIOD_MS   = 2000,
  parameter int SR04_TIMEOUT_US = 30000,
  parameter int DHT_TIMEOUT_MS  = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick_1us,
  input  logic       auto_en,
  input  logic       req_dist,
  input  logic       req_dht,
  input  logic       dist_done,
  input  logic       dht_done,
  input  logic       tx_busy,
  output logic       o_sr04_start,
  output logic       o_dht_start,
  output logic       o_send_dist,
  output logic       o_send_dht,
  output logic       o_err_sr04,
  output logic       o_err_dht,
  output logic       o_busy,
  output logic [2:0] dbg_state
);

  localparam int US_PER_MS = 1000;
  localparam int SP_W      = (SR04_PERIOD_MS > 1) ? $clog2(SR04_PERIOD_MS) : 1;
  localparam int DP_W      = (DHT_PERIOD_MS > 1) ? $clog2(DHT_PERIOD_MS) : 1;
  localparam int TO_MAX    = (SR04_TIMEOUT_US > DHT_TIMEOUT_MS) ? SR04_TIMEOUT_US : DHT_TIMEOUT_MS;
  localparam int TO_W      = $clog2(TO_MAX + 1);

  localparam logic [9:0]      US_LAST          = 10'(US_PER_MS - 1);
  localparam logic [SP_W-1:0] SR04_PERIOD_LAST = SP_W'(SR04_PERIOD_MS - 1);
  localparam logic [DP_W-1:0] DHT_PERIOD_LAST  = DP_W'(DHT_PERIOD_MS - 1);
  // The timeout fires on the tick that would make the counter reach TIMEOUT.
  localparam logic [TO_W-1:0] SR04_TO_LAST     = TO_W'(SR04_TIMEOUT_US - 1);
  localparam logic [TO_W-1:0] DHT_TO_LAST      = TO_W'(DHT_TIMEOUT_MS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN_DIST  = 3'd1,
    RUN_DHT   = 3'd2,
    SEND_DIST = 3'd3,
    SEND_DHT  = 3'd4
  } state_t;

  // last_srv encoding: 0 = SR04 served last, 1 = DHT11 served last
  localparam logic SRV_SR04 = 1'b0;
  localparam logic SRV_DHT  = 1'b1;

  state_t          state;
  logic [9:0]      us_cnt;
  logic            ms_tick;
  logic [SP_W-1:0] sr04_per_cnt;
  logic [DP_W-1:0] dht_per_cnt;
  logic            auto_dist;
  logic            auto_dht;
  logic            pend_dist;
  logic            pend_dht;
  logic            last_srv;
  logic            serve_dist;
  logic            serve_dht;
  logic            launch_dist;
  logic            launch_dht;
  logic [TO_W-1:0] to_cnt;

  // ms tick: one strobe on every 1000th microsecond tick
  assign ms_tick = i_tick_1us && (us_cnt == US_LAST);

  // Free-running microsecond divider producing the ms tick
  always_ff @(posedge clk) begin
    if (rst) begin
      us_cnt <= '0;
    end else if (i_tick_1us) begin
      if (us_cnt == US_LAST) us_cnt <= '0;
      else                   us_cnt <= us_cnt + 10'd1;
    end
  end

  // Periodic launch requests; counters are parked at 0 while auto mode is off
  assign auto_dist = auto_en && ms_tick && (sr04_per_cnt == SR04_PERIOD_LAST);
  assign auto_dht  = auto_en && ms_tick && (dht_per_cnt == DHT_PERIOD_LAST);

  // Per-sensor auto period counters
  always_ff @(posedge clk) begin
    if (rst || !auto_en) begin
      sr04_per_cnt <= '0;
      dht_per_cnt  <= '0;
    end else if (ms_tick) begin
      if (sr04_per_cnt == SR04_PERIOD_LAST) sr04_per_cnt <= '0;
      else                                   sr04_per_cnt <= sr04_per_cnt + SP_W'(1);
      if (dht_per_cnt == DHT_PERIOD_LAST)   dht_per_cnt <= '0;
      else                                   dht_per_cnt <= dht_per_cnt + DP_W'(1);
    end
  end

  // Arbitration: a lone pending sensor wins; with both pending, alternate
  assign serve_dist  = pend_dist && (!pend_dht || (last_srv == SRV_DHT));
  assign serve_dht   = pend_dht && !serve_dist;
  assign launch_dist = (state == IDLE) && serve_dist;
  assign launch_dht  = (state == IDLE) && serve_dht;

  // Pending flags: set by any request source, cleared on launch. A request on
  // the launch cycle re-arms the flag so the sensor is measured again.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_dist <= 1'b0;
      pend_dht  <= 1'b0;
    end else begin
      pend_dist <= (pend_dist && !launch_dist) || req_dist || auto_dist;
      pend_dht  <= (pend_dht && !launch_dht) || req_dht || auto_dht;
    end
  end

  // Measurement sequencer with registered start/send strobes and error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_srv     <= SRV_SR04;
      to_cnt       <= '0;
      o_sr04_start <= 1'b0;
      o_dht_start  <= 1'b0;
      o_send_dist  <= 1'b0;
      o_send_dht   <= 1'b0;
      o_err_sr04   <= 1'b0;
      o_err_dht    <= 1'b0;
    end else begin
      o_sr04_start <= 1'b0;
      o_dht_start  <= 1'b0;
      o_send_dist  <= 1'b0;
      o_send_dht   <= 1'b0;
      case (state)
        IDLE: begin
          if (serve_dist) begin
            state        <= RUN_DIST;
            last_srv     <= SRV_SR04;
            to_cnt       <= '0;
            o_sr04_start <= 1'b1;
          end else if (serve_dht) begin
            state       <= RUN_DHT;
            last_srv    <= SRV_DHT;
            to_cnt      <= '0;
            o_dht_start <= 1'b1;
          end
        end
        RUN_DIST: begin
          // done has priority over a coincident timeout
          if (dist_done) begin
            state      <= SEND_DIST;
            o_err_sr04 <= 1'b0;
          end else if (i_tick_1us) begin
            if (to_cnt == SR04_TO_LAST) begin
              state      <= IDLE;
              o_err_sr04 <= 1'b1;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
        end
        RUN_DHT: begin
          if (dht_done) begin
            state     <= SEND_DHT;
            o_err_dht <= 1'b0;
          end else if (ms_tick) begin
            if (to_cnt == DHT_TO_LAST) begin
              state     <= IDLE;
              o_err_dht <= 1'b1;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
        end
        SEND_DIST: begin
          if (!tx_busy) begin
            state       <= IDLE;
            o_send_dist <= 1'b1;
          end
        end
        SEND_DHT: begin
          if (!tx_busy) begin
            state      <= IDLE;
            o_send_dht <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy    = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_sensor_meas_scheduler.sv
// Bench for sensor_meas_scheduler: table of single-sensor transactions plus
// hand-written sequences for arbitration, merge, reset and auto mode. Every
// start/send strobe is checked in order against an expected-event queue.
module tb_sensor_meas_scheduler;

  localparam int TICK_DIV      = 4;    // clock cycles per 1 us tick in this bench
  localparam int SIM_SR04_TO   = 300;  // us
  localparam int SIM_DHT_TO_MS = 1;

  localparam logic [1:0] EV_SR04_START = 2'd0;
  localparam logic [1:0] EV_DHT_START  = 2'd1;
  localparam logic [1:0] EV_SEND_DIST  = 2'd2;
  localparam logic [1:0] EV_SEND_DHT   = 2'd3;

  localparam int W_SR04_START = 0;
  localparam int W_DHT_START  = 1;
  localparam int W_SEND_DIST  = 2;
  localparam int W_SEND_DHT   = 3;
  localparam int W_ERR_SR04   = 4;
  localparam int W_ERR_DHT    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_tick_1us = 1'b0;
  logic auto_en = 1'b0;
  logic req_dist = 1'b0;
  logic req_dht = 1'b0;
  logic dist_done = 1'b0;
  logic dht_done = 1'b0;
  logic tx_busy = 1'b0;
  logic o_sr04_start, o_dht_start, o_send_dist, o_send_dht;
  logic o_err_sr04, o_err_dht, o_busy;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  int tick_seen = 0;
  logic busy_low = 1'b0;

  typedef struct {
    logic do_reset;
    logic is_dht;
    int   done_us;   // -1: never answer
    int   busy_cyc;  // cycles tx_busy stays high from the done cycle
    logic exp_err;
  } vec_t;

  vec_t vecs[7];

  sensor_meas_scheduler #(
    .SR04_PERIOD_MS (2),
    .DHT_PERIOD_MS  (5),
    .SR04_TIMEOUT_US(SIM_SR04_TO),
    .DHT_TIMEOUT_MS (SIM_DHT_TO_MS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_tick_1us  (i_tick_1us),
    .auto_en     (auto_en),
    .req_dist    (req_dist),
    .req_dht     (req_dht),
    .dist_done   (dist_done),
    .dht_done    (dht_done),
    .tx_busy     (tx_busy),
    .o_sr04_start(o_sr04_start),
    .o_dht_start (o_dht_start),
    .o_send_dist (o_send_dist),
    .o_send_dht  (o_send_dht),
    .o_err_sr04  (o_err_sr04),
    .o_err_dht   (o_err_dht),
    .o_busy      (o_busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset / tick ----------------
  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 i_tick_1us = 1'b1;
      @(posedge clk);
      #1 i_tick_1us = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst && i_tick_1us) tick_seen <= tick_seen + 1;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- scoreboard ----------------
  function automatic void sb_pop(input logic [1:0] ev);
    logic [1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got event %0d expected none", ev);
    end else begin
      e = exp_q.pop_front();
      if (e != ev) begin
        errors++;
        $display("FAIL sb_order: got event %0d expected %0d", ev, e);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (o_sr04_start) sb_pop(EV_SR04_START);
    if (o_dht_start)  sb_pop(EV_DHT_START);
    if (o_send_dist)  sb_pop(EV_SEND_DIST);
    if (o_send_dht)   sb_pop(EV_SEND_DHT);
  end

  function automatic logic sig_of(input int w);
    case (w)
      W_SR04_START: return o_sr04_start;
      W_DHT_START:  return o_dht_start;
      W_SEND_DIST:  return o_send_dist;
      W_SEND_DHT:   return o_send_dht;
      W_ERR_SR04:   return o_err_sr04;
      default:      return o_err_dht;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Counts edges until the selected output is seen high (#1 after the edge).
  // Pulse inputs are dropped after the first edge; tx_busy drops after edge rel_n.
  task automatic wait_for(input int w, input int bound, input int rel_n, output int n);
    logic got;
    got = 1'b0;
    n = 0;
    while (!got && n < bound) begin
      @(posedge clk);
      #1;
      n++;
      req_dist  = 1'b0;
      req_dht   = 1'b0;
      dist_done = 1'b0;
      dht_done  = 1'b0;
      if (n == rel_n) tx_busy = 1'b0;
      got = sig_of(w);
      if (!got && !o_busy) busy_low = 1'b1;
    end
    if (!got) n = -1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_dist = 1'b0; req_dht = 1'b0; dist_done = 1'b0; dht_done = 1'b0;
    tx_busy = 1'b0; auto_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", int'({o_sr04_start, o_dht_start, o_send_dist, o_send_dht,
                                 o_err_sr04, o_err_dht, o_busy}), 0);
    check("reset state", int'(dbg_state), 0);
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    int nominal;
    if (v.do_reset) apply_reset();
    @(posedge clk);
    #1;
    if (v.is_dht) req_dht = 1'b1;
    else          req_dist = 1'b1;
    exp_q.push_back(v.is_dht ? EV_DHT_START : EV_SR04_START);
    wait_for(v.is_dht ? W_DHT_START : W_SR04_START, 10, 0, n);
    check($sformatf("v%0d start latency", idx), n, 2);
    busy_low = 1'b0;
    if (v.done_us < 0) begin
      nominal = v.is_dht ? SIM_DHT_TO_MS * 1000 * TICK_DIV : SIM_SR04_TO * TICK_DIV;
      wait_for(v.is_dht ? W_ERR_DHT : W_ERR_SR04, nominal + 100, 0, n);
      // 1 tick of phase slack plus the launch offset from the ms divider phase
      check_rng($sformatf("v%0d timeout cycles", idx), n, nominal - 2 * TICK_DIV,
                nominal + 2 * TICK_DIV);
      repeat (10) @(posedge clk);
      #1;
    end else begin
      repeat (v.done_us * TICK_DIV) @(posedge clk);
      #1;
      if (v.is_dht) dht_done = 1'b1;
      else          dist_done = 1'b1;
      tx_busy = (v.busy_cyc > 0);
      exp_q.push_back(v.is_dht ? EV_SEND_DHT : EV_SEND_DIST);
      wait_for(v.is_dht ? W_SEND_DHT : W_SEND_DIST, v.busy_cyc + 10, v.busy_cyc, n);
      check($sformatf("v%0d send latency", idx), n, (v.busy_cyc > 0) ? v.busy_cyc + 1 : 2);
      check($sformatf("v%0d busy held", idx), int'(busy_low), 0);
      repeat (3) @(posedge clk);
      #1;
    end
    check($sformatf("v%0d err flag", idx), int'(v.is_dht ? o_err_dht : o_err_sr04),
          int'(v.exp_err));
    check($sformatf("v%0d sb drained", idx), exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int ns;
    int nd;
    int post;
    int base;
    logic inflight;
    logic pd;
    logic ph;

    //        reset  dht   done_us busy err
    vecs[0] = '{1'b1, 1'b0, 50,  0,  1'b0};  // basic SR04
    vecs[1] = '{1'b0, 1'b0, 20,  20, 1'b0};  // SR04 send held by tx_busy
    vecs[2] = '{1'b0, 1'b0, -1,  0,  1'b1};  // SR04 timeout
    vecs[3] = '{1'b0, 1'b0, 10,  0,  1'b0};  // success clears SR04 error
    vecs[4] = '{1'b1, 1'b1, -1,  0,  1'b1};  // DHT timeout, 1 ms after reset
    vecs[5] = '{1'b0, 1'b1, 30,  0,  1'b0};  // success clears DHT error
    vecs[6] = '{1'b1, 1'b1, 100, 5,  1'b0};  // DHT with short tx_busy

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Both requested together after reset: last_srv=SR04, so DHT goes first
    apply_reset();
    @(posedge clk);
    #1;
    req_dist = 1'b1;
    req_dht  = 1'b1;
    exp_q.push_back(EV_DHT_START);
    wait_for(W_DHT_START, 10, 0, n);
    check("both dht start latency", n, 2);
    dht_done = 1'b1;
    exp_q.push_back(EV_SEND_DHT);
    wait_for(W_SEND_DHT, 10, 0, n);
    check("both dht send latency", n, 2);
    exp_q.push_back(EV_SR04_START);
    wait_for(W_SR04_START, 10, 0, n);
    check("both sr04 start after send", n, 1);
    dist_done = 1'b1;
    exp_q.push_back(EV_SEND_DIST);
    wait_for(W_SEND_DIST, 10, 0, n);
    check("both sr04 send latency", n, 2);
    repeat (20) @(posedge clk);
    #1;
    check("both sb drained", exp_q.size(), 0);

    // Request held into the launch edge re-arms pending: two measurements
    @(posedge clk);
    #1;
    req_dist = 1'b1;
    exp_q.push_back(EV_SR04_START);
    exp_q.push_back(EV_SEND_DIST);
    exp_q.push_back(EV_SR04_START);
    exp_q.push_back(EV_SEND_DIST);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    req_dist = 1'b0;
    check("merge first start", int'(o_sr04_start), 1);
    dist_done = 1'b1;
    wait_for(W_SEND_DIST, 10, 0, n);
    check("merge first send", n, 2);
    wait_for(W_SR04_START, 10, 0, n);
    check("merge relaunch", n, 1);
    dist_done = 1'b1;
    wait_for(W_SEND_DIST, 10, 0, n);
    check("merge second send", n, 2);
    repeat (20) @(posedge clk);
    #1;
    check("merge sb drained", exp_q.size(), 0);

    // Reset 10 us into RUN_DIST; a late done must not produce a send
    @(posedge clk);
    #1;
    req_dist = 1'b1;
    exp_q.push_back(EV_SR04_START);
    wait_for(W_SR04_START, 10, 0, n);
    check("rstmid start latency", n, 2);
    repeat (10 * TICK_DIV) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rstmid state", int'(dbg_state), 0);
    check("rstmid busy", int'(o_busy), 0);
    dist_done = 1'b1;
    @(posedge clk);
    #1;
    dist_done = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rstmid outputs", int'({o_sr04_start, o_dht_start, o_send_dist, o_send_dht,
                                  o_err_sr04, o_err_dht, o_busy}), 0);
    check("rstmid state after done", int'(dbg_state), 0);
    check("rstmid sb drained", exp_q.size(), 0);

    // Auto mode for 10 ms with immediate done responses
    apply_reset();
    auto_en = 1'b1;
    base = tick_seen;
    // ms ticks 2,4 SR04; 5 DHT; 6,8 SR04; 10 both (DHT first, SR04 was last)
    for (int k = 0; k < 7; k++) begin
      if (k == 2 || k == 5) begin
        exp_q.push_back(EV_DHT_START);
        exp_q.push_back(EV_SEND_DHT);
      end else begin
        exp_q.push_back(EV_SR04_START);
        exp_q.push_back(EV_SEND_DIST);
      end
    end
    ns = 0; nd = 0; post = 0;
    inflight = 1'b0; pd = 1'b0; ph = 1'b0;
    for (int c = 0; c < 60000; c++) begin
      @(posedge clk);
      #1;
      dist_done = pd;
      dht_done  = ph;
      pd = 1'b0;
      ph = 1'b0;
      if (o_sr04_start || o_dht_start) begin
        check("auto no overlap", int'(inflight), 0);
        inflight = 1'b1;
        if (o_sr04_start) begin ns++; pd = 1'b1; end
        else begin nd++; ph = 1'b1; end
      end
      if (o_send_dist || o_send_dht) inflight = 1'b0;
      if (auto_en) begin
        if (tick_seen - base >= 10 * 1000) auto_en = 1'b0;
      end else begin
        post++;
        if (post >= 2500 * TICK_DIV) break;
      end
    end
    check("auto auto_en dropped", int'(auto_en), 0);
    check("auto sr04 starts", ns, 5);
    check("auto dht starts", nd, 2);
    check("auto sb drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
